// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage fed by the execute ALU.
// Takes the ALU sum as the effective byte address. Runs one req/ack data-memory transaction
// at a time with byte-lane steering, and returns sign- or zero-extended load data.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned H/HU/W accesses.
// With the trap, no memory request is made and Err and ErrMisalign are raised with Done.
// Without the trap, surplus low address bits are dropped and ErrMisalign is tied to 0.
//
// Ports:
//   clk, rst_n             clock; synchronous active-low reset
//   Start                  access request from execute (accepted only in IDLE)
//   MemRead, MemWrite      load / store select (store wins if both set)
//   Funct3                 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALUResult, WriteData   effective byte address, store data (rs2)
//   Busy                   stall request to pipeline
//   Done, Err, ErrMisalign completion pulse and its status flags
//   ReadData               extended load result, held until the next load completes
//   MemReq/MemWe/MemAddr/MemWdata/MemBe, MemAck/MemRdata   data-memory port
module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic        ErrMisalign,
  output logic [31:0] ReadData,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  output logic [3:0]  MemBe,
  input  logic        MemAck,
  input  logic [31:0] MemRdata
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;

  logic        access;
  logic        f3_legal;
  logic        misalign;
  logic [1:0]  a_in;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] rd_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        timeout_hit;

  assign access = MemRead | MemWrite;
  assign a_in   = ALUResult[1:0];

  // Stores only have signed-width codes; BU/HU are load-only.
  always_comb begin
    f3_legal = 1'b0;
    case (Funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~MemWrite;
      default:                f3_legal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign misalign = ((Funct3[1:0] == 2'b01) && a_in[0]) ||
                    ((Funct3[1:0] == 2'b10) && (a_in != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Lane steering for the incoming request
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = WriteData;
    case (Funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << a_in;
        wdata_new = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be_new    = a_in[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{WriteData[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = WriteData;
      end
    endcase
  end

  // Load extraction and extension from the latched access
  always_comb begin
    rd_shift = MemRdata >> {addr_q[1:0], 3'b000};
    ld_byte  = rd_shift[7:0];
    ld_half  = addr_q[1] ? MemRdata[31:16] : MemRdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = MemRdata;
    endcase
  end

  // Counter holds the number of unacknowledged REQ cycles already elapsed.
  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == ACK_TIMEOUT - 1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    Busy    = 1'b0;
    case (state_q)
      StIdle: begin
        if (Start && access) begin
          Busy = 1'b1;
          if (!f3_legal || misalign) begin
            state_d = StResp;
            err_d   = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_d   = f3_legal;
`endif
          end else begin
            state_d = StReq;
            addr_d  = ALUResult;
            f3_d    = Funct3;
            we_d    = MemWrite;
            wdata_d = wdata_new;
            be_d    = be_new;
            cnt_d   = '0;
            err_d   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_d   = 1'b0;
`endif
          end
        end
      end
      StReq: begin
        Busy = 1'b1;
        if (MemAck) begin
          if (!we_q) rdata_d = ld_ext;
          state_d = StResp;
        end else if (timeout_hit) begin
          state_d = StResp;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign MemReq   = (state_q == StReq);
  assign MemWe    = we_q;
  assign MemAddr  = {addr_q[31:2], 2'b00};
  assign MemWdata = wdata_q;
  assign MemBe    = be_q;
  assign Done     = (state_q == StResp);
  assign Err      = Done & err_q;
  assign ReadData = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign ErrMisalign = Done & mis_q;
`else
  assign ErrMisalign = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit, built with a short ack timeout of 4 cycles.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        Start, MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData;
  logic        Busy, Done, Err, ErrMisalign;
  logic [31:0] ReadData;
  logic        MemReq, MemWe;
  logic [31:0] MemAddr, MemWdata;
  logic [3:0]  MemBe;
  logic        MemAck;
  logic [31:0] MemRdata;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.ACK_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Start      (Start),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Funct3     (Funct3),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .Busy       (Busy),
    .Done       (Done),
    .Err        (Err),
    .ErrMisalign(ErrMisalign),
    .ReadData   (ReadData),
    .MemReq     (MemReq),
    .MemWe      (MemWe),
    .MemAddr    (MemAddr),
    .MemWdata   (MemWdata),
    .MemBe      (MemBe),
    .MemAck     (MemAck),
    .MemRdata   (MemRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    Start = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; WriteData = wd;
    #1;
  endtask

  task automatic quiet();
    Start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b111;
    ALUResult = 32'hFFFF_FFFF; WriteData = 32'h5A5A_5A5A;
  endtask

  initial begin
    rst_n = 1'b0; MemAck = 1'b0; MemRdata = '0;
    quiet();
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_memreq", MemReq, 0);
    check("rst_rdata", ReadData, 0);
    check("rst_be", MemBe, 0);
    check("rst_addr", MemAddr, 0);

    // SW, ack in first REQ cycle
    tick();
    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF);
    check("sw_busy0", Busy, 1);
    tick();
    quiet(); MemAck = 1'b1; #1;
    check("sw_req", MemReq, 1);
    check("sw_we", MemWe, 1);
    check("sw_addr", MemAddr, 32'h100);
    check("sw_be", MemBe, 4'hF);
    check("sw_wdata", MemWdata, 32'hDEAD_BEEF);
    check("sw_busy1", Busy, 1);
    check("sw_done_early", Done, 0);
    tick();
    MemAck = 1'b0;
    // Start presented in RESP must be ignored
    issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    check("sw_done", Done, 1);
    check("sw_err", Err, 0);
    check("sw_busy_resp", Busy, 0);
    check("sw_req_resp", MemReq, 0);
    tick();
    quiet(); #1;
    check("resp_start_ign_req", MemReq, 0);
    check("resp_start_ign_done", Done, 0);

    // LB at 0x203
    issue(1'b1, 1'b0, 3'b000, 32'h203, 32'h0);
    tick();
    quiet(); MemAck = 1'b1; MemRdata = 32'h80FF_1234; #1;
    check("lb_be", MemBe, 4'b1000);
    check("lb_we", MemWe, 0);
    check("lb_addr", MemAddr, 32'h200);
    tick();
    MemAck = 1'b0;
    check("lb_done", Done, 1);
    check("lb_rdata", ReadData, 32'hFFFF_FF80);
    tick();
    // LBU at 0x203
    issue(1'b1, 1'b0, 3'b100, 32'h203, 32'h0);
    tick();
    quiet(); MemAck = 1'b1; #1;
    tick();
    MemAck = 1'b0;
    check("lbu_rdata", ReadData, 32'h0000_0080);
    tick();
    // LH at 0x200 (sign from bit 15 of low half)
    issue(1'b1, 1'b0, 3'b001, 32'h200, 32'h0);
    tick();
    quiet(); MemAck = 1'b1; MemRdata = 32'h0000_8001; #1;
    check("lh_be", MemBe, 4'b0011);
    tick();
    MemAck = 1'b0;
    check("lh_rdata", ReadData, 32'hFFFF_8001);
    tick();
    // LHU at 0x202
    issue(1'b1, 1'b0, 3'b101, 32'h202, 32'h0);
    tick();
    quiet(); MemAck = 1'b1; MemRdata = 32'h80FF_1234; #1;
    check("lhu_be", MemBe, 4'b1100);
    tick();
    MemAck = 1'b0;
    check("lhu_rdata", ReadData, 32'h0000_80FF);
    tick();

    // SH at 0x102 with 3 wait cycles; Done 5 cycles after Start
    issue(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_ABCD);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) quiet();
      MemAck = (i == 4); #1;
      check("sh_req", MemReq, 1);
      check("sh_addr", MemAddr, 32'h100);
      check("sh_be", MemBe, 4'b1100);
      check("sh_wdata", MemWdata, 32'hABCD_ABCD);
      check("sh_done_early", Done, 0);
    end
    tick();
    MemAck = 1'b0;
    check("sh_done", Done, 1);
    check("sh_err", Err, 0);
    check("sh_rdata_kept", ReadData, 32'h0000_80FF);
    tick();

    // LW timeout: MemReq for exactly 4 cycles, then Done with Err
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) quiet();
      #1;
      check("to_req", MemReq, 1);
      check("to_done_early", Done, 0);
    end
    tick();
    check("to_req_drop", MemReq, 0);
    check("to_done", Done, 1);
    check("to_err", Err, 1);
    check("to_mis", ErrMisalign, 0);
    check("to_rdata_kept", ReadData, 32'h0000_80FF);
    tick();

    // Illegal Funct3 load, then store-only-illegal BU, then no-op Start
    issue(1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
    check("ill_busy", Busy, 1);
    tick();
    quiet(); #1;
    check("ill_done", Done, 1);
    check("ill_err", Err, 1);
    check("ill_req", MemReq, 0);
    tick();
    issue(1'b0, 1'b1, 3'b100, 32'h0, 32'h0);
    tick();
    quiet(); #1;
    check("ill_st_err", Err, 1);
    check("ill_st_req", MemReq, 0);
    tick();
    issue(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    check("nop_busy", Busy, 0);
    tick();
    quiet(); #1;
    check("nop_done", Done, 0);
    check("nop_req", MemReq, 0);

    // Reset during REQ with a coincident ack
    issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    tick();
    quiet(); MemAck = 1'b1; MemRdata = 32'h0000_0055; rst_n = 1'b0; #1;
    check("rstreq_req", MemReq, 1);
    tick();
    check("rstreq_req_after", MemReq, 0);
    check("rstreq_done", Done, 0);
    check("rstreq_rdata", ReadData, 0);
    check("rstreq_busy", Busy, 0);
    rst_n = 1'b1; MemAck = 1'b0;
    tick();
    issue(1'b1, 1'b0, 3'b100, 32'h401, 32'h0);
    tick();
    quiet(); MemAck = 1'b1; MemRdata = 32'h0000_AA00; #1;
    check("post_rst_req", MemReq, 1);
    tick();
    MemAck = 1'b0;
    check("post_rst_done", Done, 1);
    check("post_rst_rdata", ReadData, 32'h0000_00AA);
    tick();

    // LW at 0x101
    issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    tick();
`ifdef LSU_MISALIGN_TRAP_EN
    quiet(); #1;
    check("mis_req", MemReq, 0);
    check("mis_done", Done, 1);
    check("mis_err", Err, 1);
    check("mis_flag", ErrMisalign, 1);
    tick();
`else
    quiet(); MemAck = 1'b1; MemRdata = 32'h1122_3344; #1;
    check("mis_req", MemReq, 1);
    check("mis_addr", MemAddr, 32'h100);
    check("mis_be", MemBe, 4'hF);
    tick();
    MemAck = 1'b0;
    check("mis_done", Done, 1);
    check("mis_err", Err, 0);
    check("mis_flag", ErrMisalign, 0);
    check("mis_rdata", ReadData, 32'h1122_3344);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the execute ALU. Takes the ALU result as the effective address, plus rs2 store data and load/store controls. Drives a single-outstanding req/ack data-memory port with byte-lane steering. Returns sign- or zero-extended load data and a Busy stall to the pipeline.

Parameters:
ACK_TIMEOUT, 16, max cycles MemReq is held without MemAck before abort; 0 disables the timeout.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
Start  in  1  access request from execute stage, sampled only in IDLE
MemRead  in  1  load
MemWrite  in  1  store
Funct3  in  3  RISC-V width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
ALUResult  in  32  effective byte address (ALU SUM)
WriteData  in  32  store data (rs2)
Busy  out  1  stall request to pipeline
Done  out  1  one-cycle completion pulse
Err  out  1  valid with Done: access aborted
ErrMisalign  out  1  valid with Done: misaligned abort (macro only, else 0)
ReadData  out  32  extended load result, held until next load Done
MemReq  out  1  memory request, held until MemAck
MemWe  out  1  1 = write
MemAddr  out  32  word address, bits [1:0] always 0
MemWdata  out  32  lane-replicated store data
MemBe  out  4  byte enables
MemAck  in  1  memory accept/complete
MemRdata  in  32  read data, valid with MemAck

Behaviour:
- Clocking/reset: one clock, clk; reset rst_n is synchronous, active-low. Reset forces IDLE and clears all outputs and registers to 0, including ReadData. Reset mid-REQ aborts silently: no Done; a coincident MemAck is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE, Start=1 with MemRead|MemWrite, legal Funct3, no trap:
  - latch address, Funct3, we and WriteData; go to REQ.
  - Inputs may change after the latch cycle.
  - MemWrite has priority if both MemRead and MemWrite are high.
- IDLE, Start=1, neither MemRead nor MemWrite: ignored, stays IDLE.
- IDLE, Start=1, illegal Funct3 (011, 110, 111; store only 000–010 legal): go to RESP with Err=1. No memory transaction.
- REQ:
  - MemReq=1; MemWe, MemAddr, MemWdata and MemBe are driven from registers and stay stable.
  - On MemAck: capture and extend the load result into ReadData; go to RESP.
  - Timeout counter clears on entry and increments each REQ cycle without ack. When it reaches ACK_TIMEOUT (if nonzero): drop MemReq, go to RESP with Err=1, ReadData unchanged.
- RESP: Done=1 for exactly one cycle, then IDLE. Start is not accepted in RESP.
- Busy (combinational) = REQ, or (IDLE & Start & (MemRead|MemWrite)). Busy is 0 in RESP so the pipeline advances on Done.
- Latency: Start to Done = 2 cycles when MemAck arrives in the first REQ cycle, +1 per wait cycle.
- Lane rules (a = address[1:0]):
  - Byte: MemBe = 1<<a; MemWdata = {4{WriteData[7:0]}}; load selects byte a.
  - Half: MemBe = a[1] ? 1100 : 0011; MemWdata = {2{WriteData[15:0]}}; load selects half a[1].
  - Word: MemBe = 1111.
  - Loads drive the same MemBe.
- Extension: B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Store Done leaves ReadData unchanged.

Optional Feature:
Macro LSU_MISALIGN_TRAP_EN.
- Defined: H/HU with a[0]=1, or W with a≠00, detected in IDLE → no MemReq; RESP next cycle with Err=1, ErrMisalign=1.
- Undefined: low address bits beyond the natural alignment are ignored and the access proceeds truncated (H uses a[1], W uses none). ErrMisalign is tied 0.

Test Plan:
1. SW, ALUResult 0x100, WriteData 0xDEADBEEF, MemAck in first REQ cycle → MemAddr 0x100, MemBe 1111, MemWe 1, MemWdata 0xDEADBEEF; Done 2 cycles after Start, Err 0, Busy 1 for 2 cycles.
2. LB at 0x203, MemRdata 0x80FF1234 → MemBe 1000, ReadData 0xFFFFFF80. LBU same → 0x00000080. LHU at 0x202 → 0x000080FF.
3. SH at 0x102, WriteData 0x1234ABCD, MemAck after 3 wait cycles → MemAddr 0x100, MemBe 1100, MemWdata 0xABCDABCD held stable; Done 5 cycles after Start.
4. ACK_TIMEOUT=4, MemAck never asserted → MemReq high exactly 4 cycles then low; Done=1, Err=1 next cycle; ReadData unchanged.
5. rst_n low in a REQ cycle with MemAck=1 → next cycle IDLE, MemReq 0, Done 0, ReadData 0; a later Start is accepted normally.
6. LW at 0x101 → macro defined: no MemReq, Done+Err+ErrMisalign 1 cycle after Start. Macro undefined: MemAddr 0x100, MemBe 1111, normal Done.
